// File: rtl/riscv_lsu_pkg.sv
// Shared load/store unit definitions: FSM encodings, timeout default, funct3 and byte-select codes.
package riscv_lsu_pkg;

    // Load extension selects as produced by the decoder
    localparam logic [2:0] FUNCT3_MEM_B  = 3'b000;
    localparam logic [2:0] FUNCT3_MEM_H  = 3'b001;
    localparam logic [2:0] FUNCT3_MEM_W  = 3'b010;
    localparam logic [2:0] FUNCT3_MEM_BU = 3'b100;
    localparam logic [2:0] FUNCT3_MEM_HU = 3'b101;

    // Access size as a byte mask before lane shifting
    localparam logic [3:0] BYTE_SEL_B = 4'b0001;
    localparam logic [3:0] BYTE_SEL_H = 4'b0011;
    localparam logic [3:0] BYTE_SEL_W = 4'b1111;

    // Cycles allowed in REQ+RESP before the access is abandoned
    localparam int LSU_TIMEOUT = 255;

    typedef enum logic [1:0] {
        LSU_ST_IDLE = 2'd0,
        LSU_ST_REQ  = 2'd1,
        LSU_ST_RESP = 2'd2,
        LSU_ST_DONE = 2'd3
    } lsu_state_t;

    // Halfwords need an even address, words need a word-aligned address
    function automatic logic lsu_misaligned(input logic [3:0] byte_sel, input logic [1:0] addr_lo);
        return ((byte_sel == BYTE_SEL_H) && addr_lo[0]) ||
               ((byte_sel == BYTE_SEL_W) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/riscv_lsu_align.sv
// Combinational lane steering: store replication and byte enables, load shift and extension.
module riscv_lsu_align
    import riscv_lsu_pkg::*;
(
    input  logic [3:0]  byte_sel,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wr_data,
    input  logic [2:0]  funct3,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] rd_ext
);

    logic [31:0] shifted;

    assign be      = byte_sel << addr_lo;
    assign shifted = rdata >> {addr_lo, 3'b000};

    // Replicate the low store bytes across every lane so the enables alone pick the target
    always_comb begin
        wdata = wr_data;
        case (byte_sel)
            BYTE_SEL_B: wdata = {4{wr_data[7:0]}};
            BYTE_SEL_H: wdata = {2{wr_data[15:0]}};
            default:    wdata = wr_data;
        endcase
    end

    // Bring the addressed lane down to bit 0 and sign/zero-extend it for write-back
    always_comb begin
        rd_ext = shifted;
        case (funct3)
            FUNCT3_MEM_B:  rd_ext = {{24{shifted[7]}}, shifted[7:0]};
            FUNCT3_MEM_BU: rd_ext = {24'h0, shifted[7:0]};
            FUNCT3_MEM_H:  rd_ext = {{16{shifted[15]}}, shifted[15:0]};
            FUNCT3_MEM_HU: rd_ext = {16'h0, shifted[15:0]};
            FUNCT3_MEM_W:  rd_ext = shifted;
            default:       rd_ext = shifted;
        endcase
    end

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit: captures the access, runs the req/gnt/rvalid handshake and stalls the core until done.
module riscv_lsu
    import riscv_lsu_pkg::*;
#(
    parameter int TIMEOUT = LSU_TIMEOUT
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_lsu_valid,
    input  logic        i_lsu_wr_en,
    input  logic [3:0]  i_lsu_byte_sel,
    input  logic [2:0]  i_lsu_funct3,
    input  logic [31:0] i_lsu_addr,
    input  logic [31:0] i_lsu_wr_data,
    output logic        o_lsu_stall,
    output logic [31:0] o_lsu_rd_data,
    output logic        o_lsu_misalign,
    output logic        o_lsu_err,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic [31:0] o_dmem_addr,
    output logic [3:0]  o_dmem_be,
    output logic [31:0] o_dmem_wdata,
    input  logic        i_dmem_gnt,
    input  logic        i_dmem_rvalid,
    input  logic [31:0] i_dmem_rdata
);

    // The counter holds the number of REQ/RESP cycles already spent, so the last allowed one sees TIMEOUT-1
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    lsu_state_t  state;
    lsu_state_t  state_next;
    logic [31:0] addr_q;
    logic [31:0] wr_data_q;
    logic [3:0]  byte_sel_q;
    logic [2:0]  funct3_q;
    logic        we_q;
    logic [7:0]  cnt;
    logic [31:0] rd_data_q;
    logic        misalign_q;
    logic        err_q;
    logic        in_req;
    logic        timeout_hit;
    logic        start_misaligned;
    logic [3:0]  be_lane;
    logic [31:0] wdata_lane;
    logic [31:0] rd_ext;

    assign in_req           = (state == LSU_ST_REQ);
    assign timeout_hit      = (cnt == TIMEOUT_LAST);
    assign start_misaligned = lsu_misaligned(i_lsu_byte_sel, i_lsu_addr[1:0]);

    riscv_lsu_align u_align (
        .byte_sel (byte_sel_q),
        .addr_lo  (addr_q[1:0]),
        .wr_data  (wr_data_q),
        .funct3   (funct3_q),
        .rdata    (i_dmem_rdata),
        .be       (be_lane),
        .wdata    (wdata_lane),
        .rd_ext   (rd_ext)
    );

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) state <= LSU_ST_IDLE;
        else       state <= state_next;
    end

    // Next-state logic; bus handshakes take priority over the timeout in the same cycle
    always_comb begin
        state_next = state;
        case (state)
            LSU_ST_IDLE: begin
                if (i_lsu_valid) state_next = start_misaligned ? LSU_ST_DONE : LSU_ST_REQ;
            end
            LSU_ST_REQ: begin
                if (i_dmem_gnt)       state_next = we_q ? LSU_ST_DONE : LSU_ST_RESP;
                else if (timeout_hit) state_next = LSU_ST_DONE;
            end
            LSU_ST_RESP: begin
                if (i_dmem_rvalid || timeout_hit) state_next = LSU_ST_DONE;
            end
            default: state_next = LSU_ST_IDLE;
        endcase
    end

    // Capture the access on IDLE exit, count bus cycles and record the result for the DONE cycle
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            addr_q     <= '0;
            wr_data_q  <= '0;
            byte_sel_q <= '0;
            funct3_q   <= '0;
            we_q       <= 1'b0;
            cnt        <= '0;
            rd_data_q  <= '0;
            misalign_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            case (state)
                LSU_ST_IDLE: begin
                    if (i_lsu_valid) begin
                        addr_q     <= i_lsu_addr;
                        wr_data_q  <= i_lsu_wr_data;
                        byte_sel_q <= i_lsu_byte_sel;
                        funct3_q   <= i_lsu_funct3;
                        we_q       <= i_lsu_wr_en;
                        cnt        <= '0;
                        rd_data_q  <= '0;
                        err_q      <= 1'b0;
                        misalign_q <= start_misaligned;
                    end
                end
                LSU_ST_REQ: begin
                    cnt <= cnt + 8'd1;
                    if (!i_dmem_gnt && timeout_hit) err_q <= 1'b1;
                end
                LSU_ST_RESP: begin
                    cnt <= cnt + 8'd1;
                    if (i_dmem_rvalid)    rd_data_q <= rd_ext;
                    else if (timeout_hit) err_q     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_lsu_stall    = i_lsu_valid && (state != LSU_ST_DONE) && !i_rst;
    assign o_lsu_rd_data  = rd_data_q;
    assign o_lsu_misalign = misalign_q;
    assign o_lsu_err      = err_q;
    assign o_dmem_req     = in_req;
    assign o_dmem_we      = in_req && we_q;
    assign o_dmem_addr    = in_req ? {addr_q[31:2], 2'b00} : 32'h0;
    assign o_dmem_be      = in_req ? be_lane : 4'h0;
    assign o_dmem_wdata   = in_req ? wdata_lane : 32'h0;

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed bench for riscv_lsu with a simple bus responder and hand-computed expectations.
module tb_riscv_lsu;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_lsu_valid;
    logic        i_lsu_wr_en;
    logic [3:0]  i_lsu_byte_sel;
    logic [2:0]  i_lsu_funct3;
    logic [31:0] i_lsu_addr;
    logic [31:0] i_lsu_wr_data;
    logic        o_lsu_stall;
    logic [31:0] o_lsu_rd_data;
    logic        o_lsu_misalign;
    logic        o_lsu_err;
    logic        o_dmem_req;
    logic        o_dmem_we;
    logic [31:0] o_dmem_addr;
    logic [3:0]  o_dmem_be;
    logic [31:0] o_dmem_wdata;
    logic        i_dmem_gnt;
    logic        i_dmem_rvalid;
    logic [31:0] i_dmem_rdata;

    int checkCount = 0;
    int failCount  = 0;

    int          stallCycles;
    int          reqCycles;
    bit          sawReq;
    logic [3:0]  busBe;
    logic [31:0] busAddr;
    logic [31:0] busWdata;
    logic        busWe;
    logic [31:0] doneRd;
    logic        doneMis;
    logic        doneErr;
    logic        doneReq;

    riscv_lsu #(.TIMEOUT(4)) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_lsu_valid    (i_lsu_valid),
        .i_lsu_wr_en    (i_lsu_wr_en),
        .i_lsu_byte_sel (i_lsu_byte_sel),
        .i_lsu_funct3   (i_lsu_funct3),
        .i_lsu_addr     (i_lsu_addr),
        .i_lsu_wr_data  (i_lsu_wr_data),
        .o_lsu_stall    (o_lsu_stall),
        .o_lsu_rd_data  (o_lsu_rd_data),
        .o_lsu_misalign (o_lsu_misalign),
        .o_lsu_err      (o_lsu_err),
        .o_dmem_req     (o_dmem_req),
        .o_dmem_we      (o_dmem_we),
        .o_dmem_addr    (o_dmem_addr),
        .o_dmem_be      (o_dmem_be),
        .o_dmem_wdata   (o_dmem_wdata),
        .i_dmem_gnt     (i_dmem_gnt),
        .i_dmem_rvalid  (i_dmem_rvalid),
        .i_dmem_rdata   (i_dmem_rdata)
    );

    // Free-running clock
    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", tag, actual, expected);
        end
    endtask

    // Present one access at a falling edge and play the memory side until the stall drops.
    // gntWait/rvalidWait < 0 means the memory never answers.
    task automatic applyStimulus(input logic we, input logic [3:0] bsel, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input int gntWait, input int rvalidWait, input logic [31:0] rdata);
        bit granted = 0;
        bit done    = 0;
        int sinceGnt = 0;
        stallCycles = 0; reqCycles = 0; sawReq = 0;
        busBe = '0; busAddr = '0; busWdata = '0; busWe = 1'b0;
        i_lsu_valid = 1'b1; i_lsu_wr_en = we; i_lsu_byte_sel = bsel;
        i_lsu_funct3 = f3; i_lsu_addr = addr; i_lsu_wr_data = wdata;
        for (int c = 0; c < 40 && !done; c++) begin
            #1;
            i_dmem_gnt = 1'b0;
            i_dmem_rvalid = 1'b0;
            if (!o_lsu_stall) begin
                done = 1;
                doneRd = o_lsu_rd_data; doneMis = o_lsu_misalign;
                doneErr = o_lsu_err; doneReq = o_dmem_req;
                i_lsu_valid = 1'b0;
            end else begin
                stallCycles++;
                if (o_dmem_req) begin
                    sawReq = 1; busBe = o_dmem_be; busAddr = o_dmem_addr;
                    busWdata = o_dmem_wdata; busWe = o_dmem_we;
                    if (gntWait >= 0 && reqCycles == gntWait) begin
                        i_dmem_gnt = 1'b1;
                        granted = 1;
                    end
                    reqCycles++;
                end else if (granted) begin
                    sinceGnt++;
                    if (rvalidWait >= 0 && sinceGnt == rvalidWait) begin
                        i_dmem_rvalid = 1'b1;
                        i_dmem_rdata = rdata;
                    end
                end
                @(negedge i_clk);
            end
        end
        if (!done) begin
            checkOutput("cycle_budget", 32'd0, 32'd1);
            i_lsu_valid = 1'b0;
            i_dmem_gnt = 1'b0;
            i_dmem_rvalid = 1'b0;
        end
        @(negedge i_clk);
    endtask

    // Directed sequence
    initial begin
        i_rst = 1'b1; i_lsu_valid = 1'b0; i_lsu_wr_en = 1'b0; i_lsu_byte_sel = 4'h0;
        i_lsu_funct3 = 3'b0; i_lsu_addr = '0; i_lsu_wr_data = '0;
        i_dmem_gnt = 1'b0; i_dmem_rvalid = 1'b0; i_dmem_rdata = '0;
        repeat (2) @(negedge i_clk);
        #1;
        checkOutput("rst_req", 32'(o_dmem_req), 32'd0);
        checkOutput("rst_stall", 32'(o_lsu_stall), 32'd0);
        checkOutput("rst_rd", o_lsu_rd_data, 32'h0);
        checkOutput("rst_be", 32'(o_dmem_be), 32'h0);
        @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);

        // sw 0x104, grant after two waiting cycles
        applyStimulus(1'b1, 4'b1111, 3'b010, 32'h104, 32'hDEADBEEF, 2, -1, 32'h0);
        checkOutput("sw_stall", stallCycles, 4);
        checkOutput("sw_be", 32'(busBe), 32'hF);
        checkOutput("sw_addr", busAddr, 32'h104);
        checkOutput("sw_wdata", busWdata, 32'hDEADBEEF);
        checkOutput("sw_we", 32'(busWe), 32'd1);
        checkOutput("sw_err", 32'(doneErr), 32'd0);

        // sb 0x203
        applyStimulus(1'b1, 4'b0001, 3'b000, 32'h203, 32'h000000A5, 0, -1, 32'h0);
        checkOutput("sb_stall", stallCycles, 2);
        checkOutput("sb_be", 32'(busBe), 32'h8);
        checkOutput("sb_addr", busAddr, 32'h200);
        checkOutput("sb_wdata", busWdata, 32'hA5A5A5A5);

        // sh 0x102 with junk in the upper half
        applyStimulus(1'b1, 4'b0011, 3'b001, 32'h102, 32'h1234BEEF, 1, -1, 32'h0);
        checkOutput("sh_be", 32'(busBe), 32'hC);
        checkOutput("sh_wdata", busWdata, 32'hBEEFBEEF);

        // Loads of 0x80017FFF
        applyStimulus(1'b0, 4'b0011, 3'b001, 32'h302, 32'h0, 0, 1, 32'h80017FFF);
        checkOutput("lh_rd", doneRd, 32'hFFFF8001);
        checkOutput("lh_stall", stallCycles, 3);
        checkOutput("lh_be", 32'(busBe), 32'hC);
        checkOutput("lh_we", 32'(busWe), 32'd0);
        applyStimulus(1'b0, 4'b0011, 3'b101, 32'h302, 32'h0, 0, 1, 32'h80017FFF);
        checkOutput("lhu_rd", doneRd, 32'h00008001);
        applyStimulus(1'b0, 4'b0001, 3'b000, 32'h300, 32'h0, 0, 1, 32'h80017FFF);
        checkOutput("lb_rd", doneRd, 32'hFFFFFFFF);
        checkOutput("lb_be", 32'(busBe), 32'h1);
        applyStimulus(1'b0, 4'b0001, 3'b100, 32'h300, 32'h0, 1, 2, 32'h80017FFF);
        checkOutput("lbu_rd", doneRd, 32'h000000FF);
        checkOutput("lbu_stall", stallCycles, 5);

        // Misaligned accesses never touch the bus
        applyStimulus(1'b0, 4'b1111, 3'b010, 32'h101, 32'h0, 0, 1, 32'h55555555);
        checkOutput("lw_mis_req", 32'(sawReq), 32'd0);
        checkOutput("lw_mis_stall", stallCycles, 1);
        checkOutput("lw_mis_flag", 32'(doneMis), 32'd1);
        checkOutput("lw_mis_rd", doneRd, 32'h0);
        applyStimulus(1'b1, 4'b0011, 3'b001, 32'h103, 32'h1111, 0, -1, 32'h0);
        checkOutput("sh_mis_req", 32'(sawReq), 32'd0);
        checkOutput("sh_mis_stall", stallCycles, 1);
        checkOutput("sh_mis_flag", 32'(doneMis), 32'd1);

        // Grant never comes: four request cycles, then error
        applyStimulus(1'b0, 4'b1111, 3'b010, 32'h100, 32'h0, -1, -1, 32'h0);
        checkOutput("to_req_cycles", reqCycles, 4);
        checkOutput("to_err", 32'(doneErr), 32'd1);
        checkOutput("to_done_req", 32'(doneReq), 32'd0);
        checkOutput("to_stall", stallCycles, 5);
        checkOutput("to_mis", 32'(doneMis), 32'd0);

        // Grant on the last allowed cycle beats the timeout
        applyStimulus(1'b1, 4'b1111, 3'b010, 32'h108, 32'h01020304, 3, -1, 32'h0);
        checkOutput("gnt_edge_err", 32'(doneErr), 32'd0);
        checkOutput("gnt_edge_stall", stallCycles, 5);

        // rvalid on the last allowed cycle beats the timeout; one later loses
        applyStimulus(1'b0, 4'b1111, 3'b010, 32'h10C, 32'h0, 0, 3, 32'hCAFEF00D);
        checkOutput("rv_edge_err", 32'(doneErr), 32'd0);
        checkOutput("rv_edge_rd", doneRd, 32'hCAFEF00D);
        applyStimulus(1'b0, 4'b1111, 3'b010, 32'h10C, 32'h0, 0, -1, 32'h0);
        checkOutput("rv_to_err", 32'(doneErr), 32'd1);
        checkOutput("rv_to_rd", doneRd, 32'h0);
        checkOutput("rv_to_stall", stallCycles, 5);

        // Reset while waiting in RESP, then a late rvalid
        i_lsu_valid = 1'b1; i_lsu_wr_en = 1'b0; i_lsu_byte_sel = 4'b1111;
        i_lsu_funct3 = 3'b010; i_lsu_addr = 32'h400; i_lsu_wr_data = '0;
        @(negedge i_clk);
        #1;
        checkOutput("rr_req", 32'(o_dmem_req), 32'd1);
        i_dmem_gnt = 1'b1;
        @(negedge i_clk);
        i_dmem_gnt = 1'b0;
        i_rst = 1'b1;
        #1;
        checkOutput("rr_stall_in_rst", 32'(o_lsu_stall), 32'd0);
        @(negedge i_clk);
        i_rst = 1'b0;
        i_lsu_valid = 1'b0;
        i_dmem_rvalid = 1'b1;
        i_dmem_rdata = 32'h12345678;
        #1;
        checkOutput("rr_req_after", 32'(o_dmem_req), 32'd0);
        checkOutput("rr_rd_after", o_lsu_rd_data, 32'h0);
        @(negedge i_clk);
        i_dmem_rvalid = 1'b0;
        #1;
        checkOutput("rr_late_rd", o_lsu_rd_data, 32'h0);
        checkOutput("rr_late_err", 32'(o_lsu_err), 32'd0);
        @(negedge i_clk);
        applyStimulus(1'b1, 4'b1111, 3'b010, 32'h500, 32'h89ABCDEF, 0, -1, 32'h0);
        checkOutput("rr_sw_stall", stallCycles, 2);
        checkOutput("rr_sw_addr", busAddr, 32'h500);
        checkOutput("rr_sw_wdata", busWdata, 32'h89ABCDEF);
        checkOutput("rr_sw_err", 32'(doneErr), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
